timer_dev: RTL and testbench

Memory-mapped countdown timer peripheral for the P7 CPU's external data bus. It is the device-side responder to the CPU's `m_data_*` bus and the source of the `interrupt` line the CPU consumes. Three word registers are decoded from a 16-byte window: CTRL, PRESET and COUNT. The bridge places it at 0x7F00, and software acknowledges the interrupt by writing CTRL.

---
 rtl/timer_pkg.sv | 39 +++
 rtl/timer_dev.sv | 128 ++++++++++++
 tb/tb_timer_dev.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer peripheral: FSM states,
// register offsets within the window, CTRL bit positions and a byte-lane
// merge helper used for partial-word writes.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_PRESET = 4'h4;
    localparam logic [3:0] REG_COUNT  = 4'h8;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Only mode 1 reloads; modes 0, 2 and 3 all act as one-shot.
    localparam logic [1:0] MODE_RELOAD = 2'd1;

    // Replace the bytes of old_val whose lane enable is set with new_val's.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  byteen);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                merged[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL / PRESET / COUNT registers in a
// 16-byte window, a four-state count FSM and an interrupt line that is
// acknowledged by any write to CTRL.
module timer_dev
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        irq
);

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;     // sticky one-shot flag
    logic        irq_pulse_q, irq_pulse_d;   // single-cycle auto-reload flag

    logic [31:0] offset;
    logic        hit;
    logic        ctrl_wr;
    logic        preset_wr;
    logic [3:0]  ctrl_new;
    logic        unused_addr_lo;

    // Byte offset inside the window; the low address bits are don't-care.
    assign offset         = {addr[31:2], 2'b00} - BASE;
    assign hit            = (offset[31:4] == 28'd0);
    assign ctrl_wr        = hit && (byteen != 4'b0000) && (offset[3:0] == REG_CTRL);
    assign preset_wr      = hit && (byteen != 4'b0000) && (offset[3:0] == REG_PRESET);
    assign unused_addr_lo = ^addr[1:0];

    // All implemented CTRL bits live in byte lane 0.
    assign ctrl_new = byteen[0] ? wdata[3:0] : ctrl_q;

    // Next-state: FSM step first, then CPU writes override EN/MODE/IM and ack the flag.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        preset_d    = preset_q;
        count_d     = count_q;
        irq_flag_d  = irq_flag_q;
        irq_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = 32'd0;
                    state_d = INT;
                end
            end
            INT: begin
                if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) begin
                    irq_pulse_d = 1'b1;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    irq_flag_d      = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (ctrl_wr) begin
            ctrl_d      = ctrl_new;
            irq_flag_d  = 1'b0;
            irq_pulse_d = 1'b0;
        end

        if (preset_wr) begin
            preset_d = byte_merge(preset_q, wdata, byteen);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ctrl_q      <= 4'd0;
            preset_q    <= 32'd0;
            count_q     <= 32'd0;
            irq_flag_q  <= 1'b0;
            irq_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            preset_q    <= preset_d;
            count_q     <= count_d;
            irq_flag_q  <= irq_flag_d;
            irq_pulse_q <= irq_pulse_d;
        end
    end

    // Zero-latency read mux; unmapped offsets read as zero.
    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (offset[3:0])
                REG_CTRL:   rdata = {28'd0, ctrl_q};
                REG_PRESET: rdata = preset_q;
                REG_COUNT:  rdata = count_q;
                default:    rdata = 32'd0;
            endcase
        end
    end

    assign irq = ctrl_q[CTRL_IM] & (irq_flag_q | irq_pulse_q);

endmodule

// File: tb/tb_timer_dev.sv
// Randomized scoreboard bench for timer_dev: the driver pushes the expected
// rdata/irq of every bus cycle, a monitor pops and compares mid-cycle.
module tb_timer_dev;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic        irq;

    always #5 clk = ~clk;

    timer_dev #(.BASE(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .irq    (irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        irq;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: registers plus a phase (0 waiting, 1 loading,
    // 2 counting, 3 expired) that advances one step per clock.
    bit        m_en, m_im, m_sticky, m_pulse;
    bit [1:0]  m_mode;
    bit [31:0] m_preset, m_count;
    int        m_phase;

    function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] be);
        bit [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic bit in_window(input bit [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'd16);
    endfunction

    function automatic bit [31:0] exp_read(input bit [31:0] a);
        bit [31:0] off;
        if (!in_window(a)) return 32'd0;
        off = (a - BASE) & ~32'h3;
        case (off)
            32'h0:   return {28'd0, m_im, m_mode, m_en};
            32'h4:   return m_preset;
            32'h8:   return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_im = 0; m_mode = 0; m_sticky = 0; m_pulse = 0;
        m_preset = 0; m_count = 0; m_phase = 0;
    endtask

    task automatic model_step(input bit [31:0] a, input bit [31:0] wd, input bit [3:0] be);
        bit        en_n, im_n, st_n, pu_n;
        bit [1:0]  mode_n;
        bit [31:0] pre_n, cnt_n, c, off;
        int        ph_n;
        en_n = m_en; im_n = m_im; mode_n = m_mode; st_n = m_sticky; pu_n = 0;
        pre_n = m_preset; cnt_n = m_count; ph_n = m_phase;
        case (m_phase)
            0: if (m_en) ph_n = 1;
            1: begin cnt_n = m_preset; ph_n = 2; end
            2: begin
                if (!m_en) ph_n = 0;
                else if (m_count > 1) cnt_n = m_count - 1;
                else begin cnt_n = 0; ph_n = 3; end
            end
            default: begin
                if (m_mode == 2'd1) pu_n = 1;
                else begin en_n = 0; st_n = 1; end
                ph_n = 0;
            end
        endcase
        if (in_window(a) && be != 4'b0000) begin
            off = (a - BASE) & ~32'h3;
            if (off == 32'h0) begin
                c = merge({28'd0, m_im, m_mode, m_en}, wd, be);
                en_n = c[0]; mode_n = c[2:1]; im_n = c[3];
                st_n = 0; pu_n = 0;
            end else if (off == 32'h4) begin
                pre_n = merge(m_preset, wd, be);
            end
        end
        m_en = en_n; m_im = im_n; m_mode = mode_n; m_sticky = st_n; m_pulse = pu_n;
        m_preset = pre_n; m_count = cnt_n; m_phase = ph_n;
    endtask

    // One bus cycle: drive on the falling edge, queue the expectation, advance the model.
    task automatic bus(input bit rst_n, input bit [31:0] a, input bit [31:0] wd, input bit [3:0] be);
        exp_t e;
        @(negedge clk);
        reset = rst_n;
        if (!rst_n) model_reset();
        addr = a; wdata = wd; byteen = be;
        e.addr = a; e.rdata = exp_read(a); e.irq = m_im & (m_sticky | m_pulse);
        q.push_back(e);
        @(posedge clk);
        if (rst_n) model_step(a, wd, be);
    endtask

    task automatic rd(input bit [31:0] off);
        bus(1'b1, BASE + off, 32'd0, 4'b0000);
    endtask

    task automatic wr(input bit [31:0] off, input bit [31:0] d);
        bus(1'b1, BASE + off, d, 4'b1111);
    endtask

    // Monitor: compare each queued expectation between the edges.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                txn++;
                if (rdata !== e.rdata || irq !== e.irq) begin
                    errors++;
                    $display("FAIL txn%0d addr=%h: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                             txn, e.addr, rdata, irq, e.rdata, e.irq);
                end else begin
                    $display("txn%0d addr=%h rdata=%h irq=%b ok", txn, e.addr, rdata, irq);
                end
            end
        end
    end

    initial begin
        bit [31:0] a, wd;
        bit [3:0]  be;
        bit        found;
        int        sel;
        reset = 1'b0; addr = '0; wdata = '0; byteen = '0;
        model_reset();

        // Reset values visible while held and after release.
        bus(1'b0, BASE + 0, 32'hFFFF_FFFF, 4'b1111);
        bus(1'b0, BASE + 4, 32'd0, 4'b0000);
        bus(1'b0, BASE + 8, 32'd0, 4'b0000);
        rd(0); rd(4); rd(8);

        // One-shot with interrupt enabled, then acknowledge.
        wr(4, 32'd3); wr(0, 32'h9);
        for (int i = 0; i < 10; i++) rd(8);
        rd(0); wr(0, 32'h0); rd(0); rd(8);

        // Auto-reload, several periods.
        wr(4, 32'd2); wr(0, 32'hB);
        for (int i = 0; i < 20; i++) rd(8);
        rd(0); wr(0, 32'h0);

        // Byte-lane merge, read-only COUNT, unmapped offset.
        wr(4, 32'h1122_3344);
        bus(1'b1, BASE + 4, 32'h0000_AB00, 4'b0010);
        rd(4);
        wr(8, 32'hFFFF_FFFF); rd(8);
        wr(12, 32'hFFFF_FFFF); rd(12);
        bus(1'b1, BASE + 16, 32'hFFFF_FFFF, 4'b1111); rd(0);

        // Masked one-shot, then setting IM acknowledges the hidden flag.
        wr(4, 32'd1); wr(0, 32'h1);
        for (int i = 0; i < 6; i++) rd(8);
        wr(0, 32'h8);
        for (int i = 0; i < 3; i++) rd(0);

        // Reset asserted mid-count at COUNT=5.
        wr(4, 32'd8); wr(0, 32'h9);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_phase == 2 && m_count == 5) found = 1;
            else rd(8);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL reach_count5: got no COUNT=5 within 20 cycles, expected one");
        end
        bus(1'b0, BASE + 8, 32'd0, 4'b0000);
        bus(1'b0, BASE + 0, 32'd0, 4'b0000);
        rd(8); rd(0); rd(8); rd(8);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = BASE + 32'(4 * (sel % 4)) + 32'($urandom_range(0, 3));
            else if (sel == 8) a = BASE + 32'd16 + 32'($urandom_range(0, 63));
            else               a = BASE - 32'($urandom_range(1, 64));
            be = ($urandom_range(0, 99) < 85) ? 4'b0000 : 4'($urandom_range(1, 15));
            wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
            bus(($urandom_range(0, 199) != 0), a, wd, be);
        end

        @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
